// File: rtl/seqdec_param.sv
// Parametrised serial sequence detector: MSB-first shift window compared against a
// loadable pattern under a don't-care mask, with registered match pulse and saturating count.
module seqdec_param #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] PATTERN_RST = WIDTH'(8'h42),
   parameter logic [WIDTH-1:0] MASK_RST    = {WIDTH{1'b1}},
   parameter int unsigned      CNT_W       = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             InA,
   input  logic             InValid,
   input  logic             Overlap,
   input  logic             PatLoad,
   input  logic [WIDTH-1:0] PatIn,
   input  logic [WIDTH-1:0] MaskIn,
   input  logic             CntClr,
   output logic             Out,
   output logic [CNT_W-1:0] MatchCnt
);

   localparam int unsigned      FILL_W    = $clog2(WIDTH + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   logic [WIDTH-1:0]  window_q,  window_d;
   logic [WIDTH-1:0]  pattern_q, pattern_d;
   logic [WIDTH-1:0]  mask_q,    mask_d;
   logic [FILL_W-1:0] fill_q,    fill_d;
   logic [FILL_W-1:0] fill_nx_c;
   logic              out_q,     out_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic              match_c;

   // Next-state: pattern load takes precedence over the serial bit on the same edge
   always_comb begin
      window_d  = window_q;
      pattern_d = pattern_q;
      mask_d    = mask_q;
      fill_d    = fill_q;
      out_d     = 1'b0;
      cnt_d     = cnt_q;
      match_c   = 1'b0;
      fill_nx_c = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);

      if (PatLoad) begin
         pattern_d = PatIn;
         mask_d    = MaskIn;
         fill_d    = '0;
      end else if (InValid) begin
         window_d = {window_q[WIDTH-2:0], InA};
         match_c  = (((window_d ^ pattern_q) & mask_q) == '0) && (fill_nx_c == FILL_FULL);
         // Non-overlapping mode forces a full fresh window before the next match
         fill_d   = (match_c && !Overlap) ? '0 : fill_nx_c;
         out_d    = match_c;
      end

      if (CntClr) begin
         cnt_d = '0;
      end else if (match_c && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         window_q  <= '0;
         pattern_q <= PATTERN_RST;
         mask_q    <= MASK_RST;
         fill_q    <= '0;
         out_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         window_q  <= window_d;
         pattern_q <= pattern_d;
         mask_q    <= mask_d;
         fill_q    <= fill_d;
         out_q     <= out_d;
         cnt_q     <= cnt_d;
      end
   end

   assign Out      = out_q;
   assign MatchCnt = cnt_q;

endmodule

// File: tb/tb_seqdec_param.sv
// Self-checking bench for seqdec_param: reference-model scoreboard plus scenario-specific checks.
module tb_seqdec_param;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, in_a, in_valid, overlap, pat_load, cnt_clr;
   logic [7:0] pat_in, mask_in;
   logic       out1, out2;
   logic [7:0] cnt1;
   logic [1:0] cnt2;

   seqdec_param #(.WIDTH(8), .CNT_W(8)) u_dut (
      .Clk(clk), .Reset(reset), .InA(in_a), .InValid(in_valid), .Overlap(overlap),
      .PatLoad(pat_load), .PatIn(pat_in), .MaskIn(mask_in), .CntClr(cnt_clr),
      .Out(out1), .MatchCnt(cnt1));

   seqdec_param #(.WIDTH(8), .CNT_W(2)) u_dut2 (
      .Clk(clk), .Reset(reset), .InA(in_a), .InValid(in_valid), .Overlap(overlap),
      .PatLoad(pat_load), .PatIn(pat_in), .MaskIn(mask_in), .CntClr(cnt_clr),
      .Out(out2), .MatchCnt(cnt2));

   typedef struct {
      logic       out;
      logic [7:0] cnt;
      logic [1:0] cnt2;
   } exp_t;

   exp_t       sb_q[$];
   int         checks = 0;
   int         errors = 0;

   logic [7:0] m_win, m_pat, m_mask;
   int         m_fill;
   logic [7:0] m_cnt;
   logic [1:0] m_cnt2;

   // Drive one edge worth of inputs, push the reference expectation, sample at negedge
   task automatic step(input logic rst, input logic a, input logic v, input logic ov,
                       input logic pl, input logic [7:0] pin, input logic [7:0] min,
                       input logic cc);
      exp_t e;
      logic match;
      int   nf;
      reset = rst; in_a = a; in_valid = v; overlap = ov;
      pat_load = pl; pat_in = pin; mask_in = min; cnt_clr = cc;
      match = 1'b0;
      if (rst) begin
         m_win = 8'h00; m_fill = 0; m_pat = 8'h42; m_mask = 8'hFF;
         m_cnt = 8'd0; m_cnt2 = 2'd0;
      end else begin
         if (pl) begin
            m_pat = pin; m_mask = min; m_fill = 0;
         end else if (v) begin
            m_win = {m_win[6:0], a};
            nf    = (m_fill >= 8) ? 8 : m_fill + 1;
            match = (((m_win ^ m_pat) & m_mask) == 8'h00) && (nf == 8);
            m_fill = (match && !ov) ? 0 : nf;
         end
         if (cc) begin
            m_cnt = 8'd0; m_cnt2 = 2'd0;
         end else if (match) begin
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
         end
      end
      e.out = match; e.cnt = m_cnt; e.cnt2 = m_cnt2;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
         e = sb_q.pop_front();
         checks++;
         if (out1 !== e.out || cnt1 !== e.cnt || out2 !== e.out || cnt2 !== e.cnt2) begin
            errors++;
            $display("FAIL reset_sb: out=%b/%b cnt=%0d/%0d required out=%b cnt=%0d/%0d",
                     out1, out2, cnt1, cnt2, e.out, e.cnt, e.cnt2);
         end
      end
      checks++;
      if (out1 !== 1'b0 || cnt1 !== 8'd0 || cnt2 !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: out=%b cnt=%0d cnt2=%0d required 0 0 0", out1, cnt1, cnt2);
      end
   endtask

   task automatic test_default_stream();
      exp_t       e;
      logic [127:0] s;
      logic       ep;
      int         exp_n;
      s = 128'h0028_850A_972E_4284_5353_28A0_8597_4253;
      exp_n = 0;
      for (int k = 0; k < 128; k++) begin
         step(1'b0, s[127-k], 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
         e = sb_q.pop_front();
         checks++;
         if (out1 !== e.out || cnt1 !== e.cnt || out2 !== e.out || cnt2 !== e.cnt2) begin
            errors++;
            $display("FAIL stream_sb bit %0d: out=%b/%b cnt=%0d/%0d required out=%b cnt=%0d/%0d",
                     k, out1, out2, cnt1, cnt2, e.out, e.cnt, e.cnt2);
         end
         ep = 1'b0;
         if (k >= 7) ep = (s[134-k -: 8] == 8'h42);
         if (ep) exp_n++;
         checks++;
         if (out1 !== ep) begin
            errors++;
            $display("FAIL stream_window bit %0d: out=%b required %b", k, out1, ep);
         end
      end
      checks++;
      if (cnt1 !== 8'(exp_n)) begin
         errors++;
         $display("FAIL stream_count: cnt=%0d required %0d", cnt1, exp_n);
      end
   endtask

   task automatic test_overlap();
      exp_t        e;
      logic [11:0] pos;
      for (int pass = 0; pass < 2; pass++) begin
         pos = 12'h000;
         step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, 8'hFF, 1'b0);
         e = sb_q.pop_front();
         checks++;
         if (out1 !== e.out || cnt1 !== e.cnt || out2 !== e.out || cnt2 !== e.cnt2) begin
            errors++;
            $display("FAIL overlap_load_sb: out=%b cnt=%0d required out=%b cnt=%0d",
                     out1, cnt1, e.out, e.cnt);
         end
         for (int k = 0; k < 12; k++) begin
            step(1'b0, (k % 2 == 0), 1'b1, (pass == 0), 1'b0, 8'h00, 8'h00, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if (out1 !== e.out || cnt1 !== e.cnt || out2 !== e.out || cnt2 !== e.cnt2) begin
               errors++;
               $display("FAIL overlap_sb bit %0d: out=%b cnt=%0d required out=%b cnt=%0d",
                        k, out1, cnt1, e.out, e.cnt);
            end
            pos[k] = out1;
         end
         checks++;
         if (pos !== ((pass == 0) ? 12'hA80 : 12'h080)) begin
            errors++;
            $display("FAIL overlap_positions ov=%0d: pulses=%h required %h",
                     (pass == 0), pos, (pass == 0) ? 12'hA80 : 12'h080);
         end
      end
   endtask

   task automatic test_stall();
      exp_t       e;
      logic [7:0] b;
      int         vi, pulses;
      b = 8'h42; vi = 0; pulses = 0;
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      void'(sb_q.pop_front());
      for (int k = 0; k < 13; k++) begin
         if (k >= 4 && k < 9) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
            checks++;
            if (out1 !== 1'b0) begin
               errors++;
               $display("FAIL stall_hold cycle %0d: out=%b required 0", k, out1);
            end
         end else begin
            step(1'b0, b[7-vi], 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
            vi++;
         end
         e = sb_q.pop_front();
         checks++;
         if (out1 !== e.out || cnt1 !== e.cnt || out2 !== e.out || cnt2 !== e.cnt2) begin
            errors++;
            $display("FAIL stall_sb cycle %0d: out=%b cnt=%0d required out=%b cnt=%0d",
                     k, out1, cnt1, e.out, e.cnt);
         end
         if (out1 === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1 || cnt1 !== 8'd1 || out1 !== 1'b1) begin
         errors++;
         $display("FAIL stall_result: pulses=%0d cnt=%0d last_out=%b required 1 1 1",
                  pulses, cnt1, out1);
      end
   endtask

   task automatic test_zero_and_mask();
      exp_t       e;
      logic [7:0] pats [4];
      logic [7:0] msks [4];
      logic [8:0] data [4];
      int         nb   [4];
      logic [8:0] pexp [4];
      logic [8:0] pos;
      pats = '{8'h00, 8'h02, 8'h02, 8'h00};
      msks = '{8'hFF, 8'h0F, 8'h0F, 8'h00};
      data = '{9'h000, 9'h1E4, 9'h1E6, 9'h0AA};
      nb   = '{8, 8, 8, 9};
      pexp = '{9'h080, 9'h080, 9'h000, 9'h180};
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      void'(sb_q.pop_front());
      for (int t = 0; t < 4; t++) begin
         pos = 9'h000;
         step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, pats[t], msks[t], 1'b0);
         void'(sb_q.pop_front());
         for (int k = 0; k < nb[t]; k++) begin
            step(1'b0, data[t][8-k], 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if (out1 !== e.out || cnt1 !== e.cnt || out2 !== e.out || cnt2 !== e.cnt2) begin
               errors++;
               $display("FAIL zero_mask_sb case %0d bit %0d: out=%b cnt=%0d required out=%b cnt=%0d",
                        t, k, out1, cnt1, e.out, e.cnt);
            end
            pos[k] = out1;
         end
         checks++;
         if (pos !== pexp[t]) begin
            errors++;
            $display("FAIL zero_mask_positions case %0d: pulses=%h required %h", t, pos, pexp[t]);
         end
      end
   endtask

   task automatic test_reset_mid_match();
      exp_t        e;
      logic [15:0] seq;
      logic [15:0] rst_at;
      int          pulses;
      // 0100001, reset, 0, then a full 0x42
      seq    = 16'b0100001_0_0_0100001;
      rst_at = 16'b0000000_1_0_0000000;
      pulses = 0;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 8'hFF, 1'b0);
      void'(sb_q.pop_front());
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      void'(sb_q.pop_front());
      for (int k = 0; k < 17; k++) begin
         if (k < 16)
            step(rst_at[15-k], seq[15-k], 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
         else
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
         e = sb_q.pop_front();
         checks++;
         if (out1 !== e.out || cnt1 !== e.cnt || out2 !== e.out || cnt2 !== e.cnt2) begin
            errors++;
            $display("FAIL rst_mid_sb bit %0d: out=%b cnt=%0d required out=%b cnt=%0d",
                     k, out1, cnt1, e.out, e.cnt);
         end
         if (out1 === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1 || out1 !== 1'b1 || cnt1 !== 8'd1) begin
         errors++;
         $display("FAIL rst_mid_result: pulses=%0d last_out=%b cnt=%0d required 1 1 1",
                  pulses, out1, cnt1);
      end
   endtask

   task automatic test_counter();
      exp_t       e;
      logic [7:0] b;
      int         pulses;
      b = 8'h42; pulses = 0;
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      void'(sb_q.pop_front());
      for (int k = 0; k < 48; k++) begin
         step(1'b0, b[7-(k%8)], 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, (k == 47));
         e = sb_q.pop_front();
         checks++;
         if (out1 !== e.out || cnt1 !== e.cnt || out2 !== e.out || cnt2 !== e.cnt2) begin
            errors++;
            $display("FAIL counter_sb bit %0d: out=%b/%b cnt=%0d/%0d required out=%b cnt=%0d/%0d",
                     k, out1, out2, cnt1, cnt2, e.out, e.cnt, e.cnt2);
         end
         if (out1 === 1'b1) pulses++;
         if (k == 39) begin
            checks++;
            if (cnt1 !== 8'd5 || cnt2 !== 2'd3) begin
               errors++;
               $display("FAIL counter_saturate: cnt=%0d cnt2=%0d required 5 3", cnt1, cnt2);
            end
         end
      end
      checks++;
      if (out1 !== 1'b1 || out2 !== 1'b1 || cnt1 !== 8'd0 || cnt2 !== 2'd0 || pulses != 6) begin
         errors++;
         $display("FAIL counter_clear_on_match: out=%b/%b cnt=%0d/%0d pulses=%0d required 1/1 0/0 6",
                  out1, out2, cnt1, cnt2, pulses);
      end
   endtask

   initial begin
      reset = 1'b1; in_a = 1'b0; in_valid = 1'b0; overlap = 1'b1;
      pat_load = 1'b0; pat_in = 8'h00; mask_in = 8'h00; cnt_clr = 1'b0;
      test_reset();
      test_default_stream();
      test_overlap();
      test_stall();
      test_zero_and_mask();
      test_reset_mid_match();
      test_counter();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
